// File: rtl/mem_access_unit.sv
// mem_access_unit: MEM-stage load/store unit bridging the pipeline to a data memory with busywait handshake.
// Optional feature MEM_TIMEOUT_EN: abort an access whose DMEM_BUSYWAIT stays high for TIMEOUT_CYCLES ACCESS cycles.
module mem_access_unit #(
   parameter int unsigned TIMEOUT_CYCLES = 255
) (
   input  logic        CLK,
   input  logic        RESET,
   input  logic        MEM_READ_EN_MEM,
   input  logic        MEM_WRITE_EN_MEM,
   input  logic [2:0]  FUNCT3_MEM,
   input  logic [31:0] ALU_RES_MEM,
   input  logic [31:0] STORE_DATA_MEM,
   output logic        DMEM_READ,
   output logic        DMEM_WRITE,
   output logic [31:0] DMEM_ADDR,
   output logic [31:0] DMEM_WRITEDATA,
   output logic [3:0]  DMEM_BYTE_EN,
   input  logic [31:0] DMEM_READDATA,
   input  logic        DMEM_BUSYWAIT,
   output logic        MEM_BUSYWAIT,
   output logic [31:0] MEM_READ_MEM,
   output logic        MEM_FAULT
);
   typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;
   state_t      state;
   logic [2:0]  funct3_q;
   logic [1:0]  off_q;
   logic        abort_q;
   logic        legal, aligned, req_ok, req_bad;
   logic [31:0] st_data, load_val;
   logic [3:0]  st_be;
   logic [15:0] lane;
`ifdef MEM_TIMEOUT_EN
   localparam logic [7:0] TO_LIM = 8'(TIMEOUT_CYCLES);
   logic [7:0]  to_cnt;
`endif
   // request legality, alignment, store lane placement and load extraction
   always_comb begin
      legal    = (FUNCT3_MEM[1:0] != 2'b11) && (!FUNCT3_MEM[2] || (MEM_READ_EN_MEM && FUNCT3_MEM[1:0] != 2'b10));
      aligned  = FUNCT3_MEM[0] ? !ALU_RES_MEM[0] : FUNCT3_MEM[1] ? (ALU_RES_MEM[1:0] == 2'b00) : 1'b1;
      req_ok   = (state == IDLE) && (MEM_READ_EN_MEM ^ MEM_WRITE_EN_MEM) && legal && aligned;
      req_bad  = (state == IDLE) && (MEM_READ_EN_MEM | MEM_WRITE_EN_MEM) && !req_ok;
      st_data  = FUNCT3_MEM[1] ? STORE_DATA_MEM : FUNCT3_MEM[0] ? {2{STORE_DATA_MEM[15:0]}} : {4{STORE_DATA_MEM[7:0]}};
      st_be    = (MEM_READ_EN_MEM || FUNCT3_MEM[1]) ? 4'b1111 : FUNCT3_MEM[0] ? (4'b0011 << ALU_RES_MEM[1:0]) : (4'b0001 << ALU_RES_MEM[1:0]);
      lane     = 16'(DMEM_READDATA >> {off_q, 3'b000});
      load_val = funct3_q[1] ? DMEM_READDATA :
                 funct3_q[0] ? {{16{!funct3_q[2] & lane[15]}}, lane} :
                               {{24{!funct3_q[2] & lane[7]}}, lane[7:0]};
   end

   assign MEM_BUSYWAIT = RESET && ((state == ACCESS) || req_ok);
   assign MEM_FAULT    = RESET && (req_bad || ((state == DONE) && abort_q));

   // access sequencer: latch request in IDLE, hold strobes through ACCESS, present result in DONE
   always_ff @(posedge CLK or negedge RESET) begin
      if (!RESET) begin
         state          <= IDLE;
         DMEM_READ      <= 1'b0;
         DMEM_WRITE     <= 1'b0;
         DMEM_ADDR      <= '0;
         DMEM_WRITEDATA <= '0;
         DMEM_BYTE_EN   <= '0;
         MEM_READ_MEM   <= '0;
         funct3_q       <= '0;
         off_q          <= '0;
         abort_q        <= 1'b0;
`ifdef MEM_TIMEOUT_EN
         to_cnt         <= '0;
`endif
      end else begin
         case (state)
            IDLE: if (req_ok) begin
               state          <= ACCESS;
               DMEM_READ      <= MEM_READ_EN_MEM;
               DMEM_WRITE     <= MEM_WRITE_EN_MEM;
               DMEM_ADDR      <= {ALU_RES_MEM[31:2], 2'b00};
               DMEM_WRITEDATA <= st_data;
               DMEM_BYTE_EN   <= st_be;
               funct3_q       <= FUNCT3_MEM;
               off_q          <= ALU_RES_MEM[1:0];
               abort_q        <= 1'b0;
`ifdef MEM_TIMEOUT_EN
               to_cnt         <= '0;
`endif
            end
            ACCESS: begin
`ifdef MEM_TIMEOUT_EN
               to_cnt <= to_cnt + 8'd1;
`endif
               if (!DMEM_BUSYWAIT) begin
                  state        <= DONE;
                  DMEM_READ    <= 1'b0;
                  DMEM_WRITE   <= 1'b0;
                  MEM_READ_MEM <= DMEM_READ ? load_val : '0;
               end
`ifdef MEM_TIMEOUT_EN
               else if (to_cnt + 8'd1 == TO_LIM) begin
                  state      <= DONE;
                  DMEM_READ  <= 1'b0;
                  DMEM_WRITE <= 1'b0;
                  abort_q    <= 1'b1;
               end
`endif
            end
            DONE: begin
               state        <= IDLE;
               MEM_READ_MEM <= '0;
               abort_q      <= 1'b0;
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule
